mac_dot_sequencer: RTL and testbench
====================================

Name: mac_dot_sequencer

Overview:
- Drives one mac_core_8x8_32 instance from the operand side and reads its accumulator back.
- Accepts a stream of signed 8-bit (a, b) operand pairs on a valid/ready interface and clears the MAC before each vector.
- Feeds exactly VEC_LEN pairs through registered operand outputs, waits for the final accumulate, then captures the dot product.
- Presents the captured result on a valid/ready output port. This is the feeder/reader end of the MAC interface used by the matrix array.

Parameters:
- VEC_LEN, 8: operand pairs per dot product; legal range >= 2.
- DATA_W, 8: operand width; must equal the MAC operand width.
- ACC_W, 32: accumulator/result width; must equal the MAC output width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts a pair this cycle.
- in_a  in  DATA_W  signed operand a.
- in_b  in  DATA_W  signed operand b.
- mac_clr  out  1  drives the MAC's synchronous active-high rst.
- mac_a  out  DATA_W  registered operand to MAC a_i.
- mac_b  out  DATA_W  registered operand to MAC b_i.
- mac_acc  in  ACC_W  MAC output_r.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  captured dot product.
- busy  out  1  high in every state except RESULT.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=CLEAR, elem count=0.
  - mac_clr=1, mac_a=0, mac_b=0.
  - out_valid=0, out_data=0, in_ready=0.
- The MAC adds a_i*b_i on every edge, so mac_a/mac_b are forced to 0 in every cycle that is not carrying an accepted pair.
- States:
  - CLEAR: mac_clr=1, in_ready=0, operand registers load 0. Next state is ACCUM after 1 cycle.
  - ACCUM: mac_clr=0, in_ready=1.
    - On in_valid&in_ready, operand registers load in_a/in_b and count increments.
    - Otherwise (bubble) operand registers load 0; bubbles of any length are legal and contribute 0.
    - A handshake when count==VEC_LEN-1 moves to FLUSH and resets count to 0.
  - FLUSH: in_ready=0. mac_a/mac_b show the last pair during this cycle; registers load 0. Next state is CAPTURE.
  - CAPTURE: in_ready=0. mac_acc now holds the full sum. On the edge: out_data<=mac_acc, out_valid<=1, next state RESULT.
  - RESULT: in_ready=0, operands 0. out_valid and out_data are held stable until out_valid&out_ready. On that handshake: out_valid<=0, next state CLEAR.
- Latency:
  - An accepted pair appears on mac_a/mac_b in the next cycle and is accumulated on the edge after that.
  - out_valid rises 2 cycles after the edge that accepts the last pair.
- Arithmetic: the result is exactly the MAC's ACC_W value; the sequencer does no arithmetic on it and wraps modulo 2^ACC_W with the MAC.
- Back-to-back vectors: minimum period is VEC_LEN+4 cycles (CLEAR, VEC_LEN accepts, FLUSH, CAPTURE, 1 RESULT cycle).
- out_ready high while out_valid is low has no effect. Inputs presented outside ACCUM are ignored.
- Reset mid-vector discards all accepted pairs. mac_clr asserted during reset and the CLEAR cycle after it guarantees the MAC restarts from 0.

Optional Feature:
- Macro: MAC_SEQ_CHECK_EN.
- Defined:
  - Adds an internal reference accumulator (ACC_W) and output port out_err (1 bit).
  - Accumulates the signed product of each accepted pair, with operands and product sign-extended, modulo 2^ACC_W.
  - Cleared in CLEAR.
  - In CAPTURE: out_err<=(mac_acc != reference). out_err is held with out_data and cleared on the result handshake and on reset.
- Undefined: no reference logic and no out_err port; behaviour otherwise identical.

Test Plan:
- Reset: rst_n low mid-sim -> mac_clr=1, in_ready=0, out_valid=0, out_data=0, mac_a=mac_b=0 immediately. After release: exactly one cycle mac_clr=1, then in_ready=1.
- VEC_LEN=8, pairs (1,1),(2,2)..(8,8) back-to-back, out_ready=1 -> out_data=204. out_valid high exactly 2 cycles after the 8th accept.
- Same pairs with in_valid low every other cycle -> out_data=204. mac_a=mac_b=0 in every bubble cycle.
- out_ready held low 5 cycles after result -> out_valid/out_data stable, in_ready=0. Then raise out_ready, feed 8×(2,3) -> next out_data=48.
- rst_n pulsed after 3 accepted pairs of (5,5), then 8×(1,2) -> out_data=16; no contribution from the partial vector.
- MAC_SEQ_CHECK_EN: bench MAC model adds +1 to output_r -> out_err=1 with out_valid. Correct model with 8×(3,4) -> out_data=96, out_err=0.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// Operand feeder and accumulator reader for one mac_core_8x8_32: clears the MAC,
// streams VEC_LEN pairs, captures the dot product. Optional MAC_SEQ_CHECK_EN adds out_err.
module mac_dot_sequencer #(
  parameter int VEC_LEN = 8,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  output logic                     mac_clr,
  output logic signed [DATA_W-1:0] mac_a,
  output logic signed [DATA_W-1:0] mac_b,
  input  logic        [ACC_W-1:0]  mac_acc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [ACC_W-1:0]  out_data,
`ifdef MAC_SEQ_CHECK_EN
  output logic                     out_err,
`endif
  output logic                     busy
);

  localparam int CNT_W = $clog2(VEC_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  typedef enum logic [2:0] {CLEAR, ACCUM, FLUSH, CAPTURE, RESULT} state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic             accept;

  assign accept = in_valid & in_ready;
  assign busy   = (state != RESULT);

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    mac_clr    = 1'b0;
    case (state)
      CLEAR: begin
        mac_clr    = 1'b1;
        next_state = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && count == LAST) next_state = FLUSH;
      end
      FLUSH:   next_state = CAPTURE;
      CAPTURE: next_state = RESULT;
      RESULT:  if (out_ready) next_state = CLEAR;
      default: next_state = CLEAR;
    endcase
  end

  // The MAC accumulates every edge, so operands are zero unless a pair was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      count     <= '0;
      mac_a     <= '0;
      mac_b     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= next_state;
      mac_a <= accept ? in_a : '0;
      mac_b <= accept ? in_b : '0;
      if (state == CLEAR)
        count <= '0;
      else if (accept)
        count <= (count == LAST) ? '0 : count + 1'b1;
      if (state == CAPTURE) begin
        out_valid <= 1'b1;
        out_data  <= mac_acc;
      end else if (state == RESULT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MAC_SEQ_CHECK_EN
  logic [ACC_W-1:0] ref_acc;

  function automatic logic [ACC_W-1:0] ext_prod(input logic signed [DATA_W-1:0] a,
                                                input logic signed [DATA_W-1:0] b);
    logic signed [ACC_W-1:0] ea;
    logic signed [ACC_W-1:0] eb;
    ea = {{(ACC_W-DATA_W){a[DATA_W-1]}}, a};
    eb = {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
    return ea * eb;
  endfunction

  // Reference tracks accepted pairs directly, one edge ahead of the MAC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_acc <= '0;
      out_err <= 1'b0;
    end else begin
      if (state == CLEAR)
        ref_acc <= '0;
      else if (accept)
        ref_acc <= ref_acc + ext_prod(in_a, in_b);
      if (state == CAPTURE)
        out_err <= (mac_acc != ref_acc);
      else if (state == RESULT && out_ready)
        out_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench for mac_dot_sequencer with a behavioural MAC model and a
// result scoreboard; define MAC_SEQ_CHECK_EN to also exercise out_err.
module tb_mac_dot_sequencer;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_a;
  logic signed [7:0] in_b;
  logic              mac_clr;
  logic signed [7:0] mac_a;
  logic signed [7:0] mac_b;
  logic       [31:0] mac_acc;
  logic              out_valid;
  logic              out_ready;
  logic       [31:0] out_data;
  logic              busy;
`ifdef MAC_SEQ_CHECK_EN
  logic              out_err;
`endif

  always #5 clk = ~clk;

  mac_dot_sequencer #(.VEC_LEN(8), .DATA_W(8), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef MAC_SEQ_CHECK_EN
    .out_err(out_err),
`endif
    .busy(busy)
  );

  // Behavioural mac_core_8x8_32: sync active-high clear, adds a*b every edge.
  logic signed [31:0] mac_int;
  logic        [31:0] mac_bias;

  function automatic logic signed [31:0] sx(input logic signed [7:0] x);
    return {{24{x[7]}}, x};
  endfunction

  always_ff @(posedge clk) begin
    if (mac_clr) mac_int <= '0;
    else         mac_int <= mac_int + sx(mac_a) * sx(mac_b);
  end
  assign mac_acc = mac_int + mac_bias;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compare on every result handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0d, expected no result", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
`ifdef MAC_SEQ_CHECK_EN
        chk("out_err", {31'd0, out_err}, {31'd0, e.err});
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [7:0] a, input logic signed [7:0] b);
    logic rdy;
    int   guard;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    guard    = 0;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      guard++;
      if (guard > 50) begin
        chk("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(exp_q.size() == 0 && in_ready === 1'b1)) begin
      tick();
      guard++;
      if (guard > 100) begin
        chk("idle_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b0; mac_bias = '0;
    repeat (3) tick();
    chk("rst_mac_clr", {31'd0, mac_clr}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_mac_a", 32'(mac_a), 32'd0);
    chk("rst_mac_b", 32'(mac_b), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("clear_mac_clr", {31'd0, mac_clr}, 32'd1);
    chk("clear_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("accum_mac_clr", {31'd0, mac_clr}, 32'd0);
    chk("accum_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back 1..8 squared: 204, result 2 cycles after last accept.
    out_ready = 1'b1;
    push(32'd204, 1'b0);
    for (int i = 1; i <= 8; i++) send(8'(i), 8'(i));
    chk("flush_mac_a", 32'(mac_a), 32'd8);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("capture_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("result_out_valid", {31'd0, out_valid}, 32'd1);
    wait_idle();

    // Bubbles between every pair, then stall the result for 5 cycles.
    out_ready = 1'b0;
    push(32'd204, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 8'(i));
      chk("pair_mac_a", 32'(mac_a), 32'(i));
      chk("pair_mac_b", 32'(mac_b), 32'(i));
      if (i < 8) begin
        tick();
        chk("bubble_mac_a", 32'(mac_a), 32'd0);
        chk("bubble_mac_b", 32'(mac_b), 32'd0);
      end
    end
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_a = 8'sd99; in_b = 8'sd99;
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_out_data", out_data, 32'd204);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_busy", {31'd0, busy}, 32'd0);
      chk("stall_mac_a", 32'(mac_a), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    push(32'd48, 1'b0);
    for (int i = 0; i < 8; i++) send(8'sd2, 8'sd3);
    wait_idle();

    // Reset after a partial vector: nothing from it may survive.
    for (int i = 0; i < 3; i++) send(8'sd5, 8'sd5);
    chk("held_out_data", out_data, 32'd48);
    rst_n = 1'b0;
    #1;
    chk("arst_mac_clr", {31'd0, mac_clr}, 32'd1);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_mac_a", 32'(mac_a), 32'd0);
    chk("arst_mac_b", 32'(mac_b), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_mac_clr", {31'd0, mac_clr}, 32'd1);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rel_accum_mac_clr", {31'd0, mac_clr}, 32'd0);
    chk("rel_accum_in_ready", {31'd0, in_ready}, 32'd1);
    push(32'd16, 1'b0);
    for (int i = 0; i < 8; i++) send(8'sd1, 8'sd2);
    wait_idle();

    // Faulty MAC (+1 on its output), then a correct one.
    mac_bias = 32'd1;
    push(32'd97, 1'b1);
    for (int i = 0; i < 8; i++) send(8'sd3, 8'sd4);
    wait_idle();
    mac_bias = 32'd0;
    push(32'd96, 1'b0);
    for (int i = 0; i < 8; i++) send(8'sd3, 8'sd4);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
